spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parametrised SPI master that replaces the fixed 8-bit, single-mode master. It supports configurable word width, SCK divider, chip-select count, all four CPOL/CPHA modes and MSB/LSB-first ordering. A start/busy/done handshake connects it to a host controller, and it drives one of NUM_CS active-low chip selects on the SPI bus.

Parameters:
DATA_W, 8, bits per transfer (2..32)
CLK_DIV, 4, clk cycles per SCK half-period (>=1)
NUM_CS, 1, number of chip-select outputs (1..8)
CS_W, $clog2(NUM_CS) min 1, width of cs_sel (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request transfer; accepted only when busy=0
tx_data  in  DATA_W  word to send; captured on accepting edge
cs_sel  in  CS_W  target slave index; captured on accepting edge
cpol  in  1  SCK idle level; captured on accepting edge
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured on accepting edge
lsb_first  in  1  bit order; captured on accepting edge
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at end of transfer
rx_data  out  DATA_W  received word; valid from done onward, held until next done
cs_n  out  NUM_CS  active-low chip selects, at most one low
sck  out  1  serial clock
mosi  out  1  serial data out
miso  in  1  serial data in, sampled directly with no synchroniser

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, rx_data=0, cs_n=all 1, sck=0, mosi=0, divider and bit counters cleared. Reset mid-transfer aborts immediately with no done pulse.
- IDLE: sck=captured cpol (0 after reset). start=1 latches tx_data into the shift register, plus cs_sel, cpol, cpha and lsb_first. Next cycle: busy=1, cs_n[cs_sel]=0, state=SETUP.
- cs_sel >= NUM_CS: the transfer still runs and timing is unchanged, but no cs_n goes low.
- Divider: a tick fires every CLK_DIV clk cycles while not IDLE. Every state step and SCK edge occurs on a tick.
- SETUP (1 half-period): if cpha=0, mosi=first bit during SETUP. On tick, go to XFER.
- XFER: 2*DATA_W ticks, each toggling sck; edge index counts 0..2*DATA_W-1.
  - Even index = leading edge, odd index = trailing edge.
  - cpha=0: sample miso on leading edges; shift out the next bit on trailing edges (except the last).
  - cpha=1: drive the next bit on leading edges; sample miso on trailing edges.
  - After the final edge, sck equals cpol; go to HOLD.
- HOLD (1 half-period): cs_n stays low. On tick: cs_n=all 1, rx_data=assembled word, done=1 for one cycle, busy=0 in the same cycle, state=IDLE.
- Bit order: lsb_first=0 sends tx_data[DATA_W-1] first and shifts received bits into the LSB. lsb_first=1 mirrors this: tx bit 0 goes first, and the first received bit lands at rx bit 0.
- Latency: done is asserted exactly (2*DATA_W+2)*CLK_DIV+1 clk cycles after the start-accepting edge.
- start while busy=1: ignored, not queued. start in the same cycle as done: ignored, because busy is still 1 at that edge; accepted on the next cycle.
- Input changes during a transfer have no effect, since all inputs were captured at acceptance.

Decomposition:
- Package spi_master_pkg holds:
  - state enum: IDLE, SETUP, XFER, HOLD
  - localparams for the mode encodings (MODE0..MODE3 = {cpol, cpha})
  - a function for the CS_W computation
- Sub-module spi_clk_tick holds the CLK_DIV counter. It has an enable input and a one-cycle tick output, and clears when disabled.
- Shift register, edge counter and FSM stay in the top module.

Test Plan:
1. Mode 0, DATA_W=8, CLK_DIV=4, tx=0xA5, miso looped from mosi -> rx_data=0xA5. done occurs 73 cycles after acceptance. 8 rising sck edges. sck idles 0. cs_n[0] low for the whole frame.
2. Mode 3 (cpol=1, cpha=1), tx=0x3C, slave model returns 0xC3 -> sck idles 1. Sampling on rising (trailing) edges gives rx_data=0xC3. mosi bits observed as 0,0,1,1,1,1,0,0.
3. lsb_first=1, mode 1, tx=0x01 -> first mosi bit=1, then seven 0s. Slave sending 1,0,0,0,0,0,0,0 -> rx_data=0x01.
4. NUM_CS=4, cs_sel=2 -> only cs_n[2] falls (cs_n=4'b1011). Second start pulsed mid-transfer -> ignored, exactly one done. Then cs_sel=5 with CS_W=2 is impossible, so instead NUM_CS=3 with cs_sel=3 -> cs_n stays 3'b111 and done still arrives.
5. DATA_W=16, CLK_DIV=1, tx=0xBEEF, loopback -> rx_data=0xBEEF. done 35 cycles after acceptance. start asserted in the done cycle is accepted only on the following edge.
6. rst_n pulsed low mid-XFER (after 5 edges) -> cs_n=all 1, sck=0, busy=0 and rx_data=0 asynchronously. No done pulse. A new transfer afterwards completes normally.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// SCK half-period divider: one-cycle registered tick every CLK_DIV enabled cycles.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// SPI master with configurable width, divider, chip-select count, mode and bit order.
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int EC_W = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  state_t            state;
  logic              tick;
  logic              tick_en;
  logic [EC_W-1:0]   edge_cnt;
  logic              cpol_r, cpha_r, lsb_r;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [NUM_CS-1:0] cs_dec;
  logic              accept, xfer_tick, lead, last_edge, drive_en, sample_en;

  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic lsb,
                                                 input logic b);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  assign tick_en = (state != IDLE);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tick  (tick)
  );

  // Out-of-range selects leave every chip select high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
  end

  assign accept    = (state == IDLE) && start;
  assign xfer_tick = (state == XFER) && tick;
  assign lead      = ~edge_cnt[0];
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign drive_en  = xfer_tick && (cpha_r ? lead : (!lead && !last_edge));
  assign sample_en = xfer_tick && (lead ^ cpha_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      cs_n     <= '1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      edge_cnt <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            lsb_r    <= lsb_first;
            sck      <= cpol;
            busy     <= 1'b1;
            cs_n     <= cs_dec;
            edge_cnt <= '0;
            if (!cpha) mosi <= head_bit(tx_data, lsb_first);
            state    <= SETUP;
          end else begin
            sck <= cpol_r;
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER: begin
          if (tick) begin
            sck <= ~sck;
            if (drive_en) mosi <= head_bit(tx_sh, lsb_r);
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= '1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // With cpha=0 the first bit is already on mosi, so the register is pre-shifted.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sh <= cpha ? tx_data : shift_tx(tx_data, lsb_first);
      rx_sh <= '0;
    end else begin
      if (drive_en)  tx_sh <= shift_tx(tx_sh, lsb_r);
      if (sample_en) rx_sh <= shift_rx(rx_sh, lsb_r, miso);
    end
  end

endmodule
